ctrl_pad_sequencer: RTL



---
 rtl/ctrl_pad_sequencer_if.sv | 39 +++
 rtl/ctrl_pad_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ctrl_pad_sequencer_if.sv
// Host/pad-side bundle of the control-pad sequencer.
// Handshake: a valve word transfers on a rising clk edge where cfg_valid and
// cfg_ready are both high; cfg_ready is combinational, and the host may raise
// or drop cfg_valid at any time. Valid does not wait for ready.
interface ctrl_pad_sequencer_if #(
    parameter int N_CTRL = 16,
    parameter int N_PUMP = 3,
    parameter int CNT_W  = 16
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [N_CTRL-1:0] cfg_valves;
    logic [CNT_W-1:0]  cfg_dwell;
    logic              pump_en;
    logic              pump_dir;
    logic [CNT_W-1:0]  pump_period;
    logic              flush_req;
    logic [CNT_W-1:0]  flush_cycles;
    logic [N_CTRL-1:0] valve_out;
    logic [N_PUMP-1:0] pump_out;
    logic [N_CTRL-1:0] flush_out;
    logic              busy;
    logic              flush_done;
    logic [1:0]        state_dbg;    // FSM state: 0 idle, 1 hold, 2 flush

    modport master (
        output cfg_valid, cfg_valves, cfg_dwell, pump_en, pump_dir,
               pump_period, flush_req, flush_cycles,
        input  cfg_ready, valve_out, pump_out, flush_out, busy, flush_done,
               state_dbg
    );

    modport slave (
        input  cfg_valid, cfg_valves, cfg_dwell, pump_en, pump_dir,
               pump_period, flush_req, flush_cycles,
        output cfg_ready, valve_out, pump_out, flush_out, busy, flush_done,
               state_dbg
    );
endinterface

// File: rtl/ctrl_pad_sequencer.sv
// Control-layer pad sequencer: valve words with dwell, a channel-by-channel
// flush sweep, and a free-running peristaltic pump pattern generator.
module ctrl_pad_sequencer #(
    parameter int N_CTRL = 16,
    parameter int N_PUMP = 3,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ctrl_pad_sequencer_if.slave  bus
);
    localparam int CH_W = (N_CTRL > 1) ? $clog2(N_CTRL) : 1;
    localparam int S_W  = $clog2(2 * N_PUMP);
    localparam logic [S_W-1:0]  S_LAST  = S_W'(2 * N_PUMP - 1);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_CTRL - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [CH_W-1:0]   ch, ch_nxt;
    logic [N_CTRL-1:0] word_q, word_nxt;     // word restored after a flush
    logic [N_CTRL-1:0] valve_q, valve_nxt;
    logic [N_CTRL-1:0] flush_q, flush_nxt;
    logic              busy_q, busy_nxt;
    logic              done_q, done_nxt;
    logic              accept, flush_start, cnt_zero, ch_last;

    logic [S_W-1:0]    s_q;
    logic [CNT_W-1:0]  pcnt;
    logic [N_PUMP-1:0] pump_q, pattern;
    logic [S_W-1:0]    half, partner;

    // A pending flush request blocks acceptance so the flush always wins.
    assign bus.cfg_ready = (state == ST_IDLE) && !bus.flush_req;
    assign accept        = bus.cfg_valid && bus.cfg_ready;
    assign flush_start   = (state == ST_IDLE) && bus.flush_req;
    assign cnt_zero      = (cnt == '0);
    assign ch_last       = (ch == CH_LAST);

    assign bus.valve_out  = valve_q;
    assign bus.pump_out   = pump_q;
    assign bus.flush_out  = flush_q;
    assign bus.busy       = busy_q;
    assign bus.flush_done = done_q;
    assign bus.state_dbg  = state;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: hold until dwell expires, flush until last channel expires.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (flush_start)  state_nxt = ST_FLUSH;
                else if (accept)  state_nxt = ST_HOLD;
            end
            ST_HOLD:  if (cnt_zero) state_nxt = ST_IDLE;
            ST_FLUSH: if (cnt_zero && ch_last) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output/datapath next values: counter, channel and the pad words.
    always_comb begin
        cnt_nxt   = cnt;
        ch_nxt    = ch;
        word_nxt  = word_q;
        valve_nxt = valve_q;
        flush_nxt = flush_q;
        done_nxt  = 1'b0;
        busy_nxt  = (state_nxt != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (flush_start) begin
                    cnt_nxt   = bus.flush_cycles;
                    ch_nxt    = '0;
                    flush_nxt = N_CTRL'(1);
                    valve_nxt = word_q & ~N_CTRL'(1);
                end else if (accept) begin
                    cnt_nxt   = bus.cfg_dwell;
                    word_nxt  = bus.cfg_valves;
                    valve_nxt = bus.cfg_valves;
                end
            end
            ST_HOLD: begin
                if (!cnt_zero) cnt_nxt = cnt - CNT_W'(1);
            end
            ST_FLUSH: begin
                if (!cnt_zero) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else if (ch_last) begin
                    flush_nxt = '0;
                    valve_nxt = word_q;
                    done_nxt  = 1'b1;
                end else begin
                    ch_nxt    = ch + CH_W'(1);
                    cnt_nxt   = bus.flush_cycles;
                    flush_nxt = flush_q << 1;
                    valve_nxt = word_q & ~(flush_q << 1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset leaves every valve closed and no flush line active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            ch      <= '0;
            word_q  <= '1;
            valve_q <= '1;
            flush_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            ch      <= ch_nxt;
            word_q  <= word_nxt;
            valve_q <= valve_nxt;
            flush_q <= flush_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
        end
    end

    // Pump step decode: valve s/2 is open, plus its successor on odd steps.
    always_comb begin
        half    = s_q >> 1;
        partner = (half == S_W'(N_PUMP - 1)) ? '0 : half + S_W'(1);
        pattern = '1;
        for (int j = 0; j < N_PUMP; j++) begin
            if ((S_W'(j) == half) || (s_q[0] && (S_W'(j) == partner)))
                pattern[j] = 1'b0;
        end
    end

    // Pump period counter and step index; both freeze while the pump is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q    <= '0;
            pcnt   <= '0;
            pump_q <= '1;
        end else if (bus.pump_en) begin
            pump_q <= pattern;
            if (pcnt == bus.pump_period) begin
                pcnt <= '0;
                if (bus.pump_dir) s_q <= (s_q == '0) ? S_LAST : s_q - S_W'(1);
                else              s_q <= (s_q == S_LAST) ? '0 : s_q + S_W'(1);
            end else begin
                pcnt <= pcnt + CNT_W'(1);
            end
        end else begin
            pump_q <= '1;
        end
    end
endmodule
